// File: rtl/cpu_defs.sv
// Shared definitions for the fetch path: one-hot FSM states, instruction class codes, default widths.
package cpu_defs;

    localparam int INSTR_WIDTH = 20;
    localparam int PC_BITS     = 5;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        FETCH  = 5'b00010,
        WAIT   = 5'b00100,
        ISSUE  = 5'b01000,
        HALTED = 5'b10000
    } state_t;

    localparam logic [1:0] CLS_HALT  = 2'b00;
    localparam logic [1:0] CLS_STD   = 2'b01;
    localparam logic [1:0] CLS_LOAD  = 2'b10;
    localparam logic [1:0] CLS_STORE = 2'b11;

endpackage

// File: rtl/pc_reg.sv
// Program counter: load has priority over increment; increment wraps modulo 2^PC_BITS.
module pc_reg #(
    parameter int PC_BITS = cpu_defs::PC_BITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [PC_BITS-1:0] load_val,
    input  logic               inc,
    output logic [PC_BITS-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst)       pc <= '0;
        else if (load) pc <= load_val;
        else if (inc)  pc <= pc + 1'b1;
    end

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: PC, synchronous imem read, one held instruction on a valid/done handshake.
// Optional retire counter output enabled by defining FETCH_SEQ_RETIRE_CNT_EN.
module instr_fetch_seq
    import cpu_defs::*;
#(
    parameter int INSTR_WIDTH = cpu_defs::INSTR_WIDTH,
    parameter int PC_BITS     = cpu_defs::PC_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [PC_BITS-1:0]     start_addr,
    output logic                   imem_en,
    output logic [PC_BITS-1:0]     imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    input  logic                   instr_done,
    input  logic                   jump_en,
    input  logic [PC_BITS-1:0]     jump_addr,
    output logic                   busy,
    output logic                   halted,
    output logic [4:0]             state_dbg
`ifdef FETCH_SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0]            retire_cnt
`endif
);

    // Handshake: instr is valid while instr_valid=1 (ISSUE only) and stays stable
    // until instr_done is sampled high; instr_valid drops the following cycle.
    state_t             state, state_nxt;
    logic               start_acc, done_acc;
    logic [PC_BITS-1:0] pc;

    assign start_acc = start && ((state == IDLE) || (state == HALTED));
    assign done_acc  = instr_done && (state == ISSUE);

    pc_reg #(.PC_BITS(PC_BITS)) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (start_acc || (done_acc && jump_en)),
        .load_val (start_acc ? start_addr : jump_addr),
        .inc      (done_acc && !jump_en),
        .pc       (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_acc) state_nxt = FETCH;
            FETCH:   state_nxt = WAIT;
            WAIT:    state_nxt = (imem_rdata[INSTR_WIDTH-1 -: 2] == CLS_HALT) ? HALTED : ISSUE;
            ISSUE:   if (done_acc) state_nxt = FETCH;
            HALTED:  if (start_acc) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_en     = (state == FETCH);
        instr_valid = (state == ISSUE);
        busy        = (state == FETCH) || (state == WAIT) || (state == ISSUE);
        halted      = (state == HALTED);
    end

    // The PC register itself drives the memory address, so it is registered and only moves on load/inc.
    assign imem_addr = pc;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst)                instr <= '0;
        else if (state == WAIT) instr <= imem_rdata;
    end

`ifdef FETCH_SEQ_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || start_acc) retire_cnt <= '0;
        else if (done_acc)    retire_cnt <= retire_cnt + 16'd1;
    end
`endif

endmodule
